// File: rtl/if_stage_prefetch.sv
`default_nettype none
//==============================================================================
// if_stage_prefetch : instruction-fetch stage with a credit-limited prefetch queue
// Optional macro IF_PERF_COUNTERS_EN adds saturating performance counters.
// Revision: 1.0
//==============================================================================
module if_stage_prefetch #(
    parameter int unsigned              BIT_NUMBER = 32,
    parameter int unsigned              FIFO_DEPTH = 4,
    parameter logic [BIT_NUMBER-1:0]    RESET_PC   = '0,
    parameter logic [BIT_NUMBER-1:0]    PC_STEP    = BIT_NUMBER'(4)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    branch_taken,
    input  logic [BIT_NUMBER-1:0]   branch_address,
    output logic                    imem_req,
    output logic [BIT_NUMBER-1:0]   imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [BIT_NUMBER-1:0]   imem_rdata,
    output logic                    if_valid,
    output logic [BIT_NUMBER-1:0]   instruction,
    output logic [BIT_NUMBER-1:0]   pc
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_squashed,
    output logic [31:0]             perf_empty_cycles
`endif
);

    localparam int unsigned         c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned         c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W:0]    c_DEPTH_EXT = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);

    logic [BIT_NUMBER-1:0]  r_fetch_pc;
    logic [BIT_NUMBER-1:0]  r_q_instr [FIFO_DEPTH];
    logic [BIT_NUMBER-1:0]  r_q_pc    [FIFO_DEPTH];
    logic [BIT_NUMBER-1:0]  r_af_addr [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_rd_ptr, r_wr_ptr, r_af_rd, r_af_wr;
    logic [c_CNT_W-1:0]     r_count, r_outstanding, r_drop;
    logic                   r_run;

    logic                   w_if_valid, w_issue, w_discard, w_push, w_pop;
    logic [c_CNT_W-1:0]     w_out_after_rsp;

    assign w_if_valid      = (r_count != '0);
    assign w_issue         = imem_req && imem_gnt;
    assign w_discard       = imem_rvalid && (r_drop != '0);
    assign w_push          = imem_rvalid && (r_drop == '0);
    assign w_pop           = w_if_valid && !freeze;
    assign w_out_after_rsp = r_outstanding - c_CNT_W'(imem_rvalid);

    // Credit: buffered plus in-flight words never exceed the queue size
    assign imem_req  = r_run && !branch_taken &&
                       (({1'b0, r_count} + {1'b0, r_outstanding}) < c_DEPTH_EXT);
    assign imem_addr = r_fetch_pc;

    assign if_valid    = w_if_valid;
    assign instruction = w_if_valid ? r_q_instr[r_rd_ptr] : '0;
    assign pc          = w_if_valid ? (r_q_pc[r_rd_ptr] + PC_STEP) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_af_rd       <= '0;
            r_af_wr       <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_run <= 1'b1;
            if (branch_taken) begin
                // Everything still in flight belongs to the old path
                r_fetch_pc    <= branch_address;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
                r_af_rd       <= '0;
                r_af_wr       <= '0;
                r_count       <= '0;
                r_outstanding <= w_out_after_rsp;
                r_drop        <= w_out_after_rsp;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                    r_af_wr    <= r_af_wr + c_PTR_ONE;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                    r_af_rd  <= r_af_rd + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                r_outstanding <= r_outstanding + c_CNT_W'(w_issue) - c_CNT_W'(imem_rvalid);
                r_drop        <= r_drop - c_CNT_W'(w_discard);
                r_count       <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!branch_taken && w_issue) begin
            r_af_addr[r_af_wr] <= r_fetch_pc;
        end
        if (!branch_taken && w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= r_af_addr[r_af_rd];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && !branch_taken && w_push) begin
            assert (r_count != c_DEPTH_CNT);
        end
    end
`endif

`ifdef IF_PERF_COUNTERS_EN
    logic [c_CNT_W:0]   w_sq_inc;
    logic [32:0]        w_sq_sum;

    assign w_sq_inc = branch_taken ? ({1'b0, r_count} + (c_CNT_W + 1)'(imem_rvalid))
                                   : (c_CNT_W + 1)'(w_discard);
    assign w_sq_sum = {1'b0, perf_squashed} + 33'(w_sq_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched      <= '0;
            perf_squashed     <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (w_issue && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_squashed <= w_sq_sum[32] ? '1 : w_sq_sum[31:0];
            if (!w_if_valid && !branch_taken && (perf_empty_cycles != '1)) begin
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage_prefetch.sv
`default_nettype none
//==============================================================================
// tb_if_stage_prefetch : randomized bench with an epoch-tagged memory/queue model
// Revision: 1.0
//==============================================================================
module tb_if_stage_prefetch;

    localparam int c_DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          ready;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc;

    if_stage_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .instruction    (instruction),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          epoch = 0;
    bit          run = 1'b0;
    logic [31:0] mpc = '0;
    mreq_t       memq[$];
    logic [31:0] q[$];
    logic [63:0] seen[$];
    bit          rec_en = 1'b0;
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_instr, obs_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT to model, advance model across the edge
    task automatic step(input bit g, input bit fr, input bit bt, input logic [31:0] ba, input int lat);
        bit    rv, exp_req, pop;
        mreq_t e;
        @(negedge clk);
        imem_gnt       = g;
        freeze         = fr;
        branch_taken   = bt;
        branch_address = ba;
        rv             = (memq.size() > 0) && (memq[0].ready <= cyc);
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(memq[0].addr) : $urandom;
        #2;
        exp_req = run && !bt && ((q.size() + memq.size()) < c_DEPTH);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, mpc);
        chk("if_valid", {31'd0, if_valid}, {31'd0, (q.size() > 0)});
        chk("instruction", instruction, (q.size() > 0) ? mem_word(q[0]) : 32'd0);
        chk("pc", pc, (q.size() > 0) ? (q[0] + 32'd4) : 32'd0);
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = if_valid;
        obs_instr = instruction;
        obs_pc    = pc;
        if (rec_en && if_valid && !fr && !bt) seen.push_back({instruction, pc});
        pop = (q.size() > 0) && !fr;
        if (bt) begin
            q.delete();
            mpc = ba;
            epoch++;
            if (rv) void'(memq.pop_front());
        end else begin
            if (pop) void'(q.pop_front());
            if (rv) begin
                e = memq.pop_front();
                if (e.ep == epoch) q.push_back(e.addr);
            end
            if (exp_req && g) begin
                memq.push_back('{addr: mpc, ep: epoch, ready: cyc + lat});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst          = 1'b1;
        imem_rvalid  = 1'b0;
        imem_gnt     = 1'b0;
        branch_taken = 1'b0;
        freeze       = 1'b0;
        @(posedge clk);
        run = 1'b1;
        cyc++;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_instr"}, instruction, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
    endtask

    initial begin
        int          first_valid;
        bool_t_dummy: begin end
        // Reset state and first fetches with a 1-cycle memory
        repeat (2) @(negedge clk);
        #1;
        chk_zero_outputs("reset");
        release_reset();
        rec_en      = 1'b1;
        first_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1);
            if (i == 1) begin
                chk("t1_first_req", {31'd0, obs_req}, 32'd1);
                chk("t1_first_addr", obs_addr, 32'h0);
            end
            if (obs_valid && first_valid == 0) first_valid = i;
        end
        rec_en = 1'b0;
        chk("t1_first_valid_cycle", first_valid, 3);
        if (seen.size() >= 3) begin
            chk("t1_instr0", seen[0][63:32], 32'hC0DE_0000);
            chk("t1_pc0", seen[0][31:0], 32'h4);
            chk("t1_instr1", seen[1][63:32], 32'hC0DE_0004);
            chk("t1_pc2", seen[2][31:0], 32'hC);
        end else begin
            chk("t1_seen_count", seen.size(), 3);
        end

        // Consumer stall: queue fills, fetching stops, then drains in order
        repeat (10) step(1'b1, 1'b1, 1'b0, '0, 1);
        chk("t2_req_when_full", {31'd0, obs_req}, 32'd0);
        chk("t2_valid_held", {31'd0, obs_valid}, 32'd1);
        repeat (10) step(1'b1, 1'b0, 1'b0, '0, 1);

        // Branch with responses in flight on a 3-cycle memory
        for (int i = 0; i < 20 && memq.size() < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 3);
        chk("t3_outstanding_reached", memq.size(), 3);
        step(1'b1, 1'b0, 1'b1, 32'h100, 3);
        step(1'b1, 1'b0, 1'b0, '0, 3);
        chk("t3_req_after_branch", {31'd0, obs_req}, 32'd1);
        chk("t3_addr_after_branch", obs_addr, 32'h100);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                step(1'b1, 1'b0, 1'b0, '0, 3);
                if (obs_valid) begin
                    got = 1'b1;
                    chk("t3_first_pc", obs_pc, 32'h104);
                    chk("t3_first_instr", obs_instr, 32'hC0DE_0100);
                end
            end
            if (!got) chk("t3_valid_timeout", 32'd0, 32'd1);
        end

        // Grant withheld
        repeat (5) step(1'b0, 1'b0, 1'b0, '0, 1);
        repeat (6) step(1'b1, 1'b0, 1'b0, '0, 1);

        // Branch coinciding with pop, push and rvalid
        step(1'b1, 1'b0, 1'b1, 32'h2000, 1);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                step(1'b1, 1'b0, 1'b0, '0, 1);
                if (obs_valid) begin
                    got = 1'b1;
                    chk("t5_first_pc", obs_pc, 32'h2004);
                end
            end
            if (!got) chk("t5_valid_timeout", 32'd0, 32'd1);
        end

        // Asynchronous reset mid-stream with requests outstanding
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, 3);
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        q.delete();
        memq.delete();
        mpc = '0;
        run = 1'b0;
        release_reset();
        step(1'b1, 1'b0, 1'b0, '0, 1);
        chk("t6_restart_addr", obs_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          g, fr, bt;
            logic [31:0] ba;
            g  = ($urandom_range(0, 9) < 7);
            fr = ($urandom_range(0, 9) < 3);
            bt = ($urandom_range(0, 99) < 5);
            ba = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step(g, fr, bt, ba, $urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
